// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller between instruction fetch (IF) and load/store (MEM).
// Latency: accept to mc_req is 2 cycles; mc_done to if_done/mem_done is 1 cycle.
// Backpressure: one holding slot per requester (x_ready = slot empty); rdy=0 freezes every register.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mc_req,
    output logic              mc_we,
    output logic [1:0]        mc_size,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    state_t            state;
    state_t            state_nxt;

    logic              slot_if_vld;
    logic [ADDR_W-1:0] slot_if_addr;
    logic              slot_mem_vld;
    logic              slot_mem_we;
    logic [1:0]        slot_mem_size;
    logic [ADDR_W-1:0] slot_mem_addr;
    logic [DATA_W-1:0] slot_mem_wdata;

    logic [CNT_W-1:0]  starve_cnt;
    logic              squash;

    logic              if_live;
    logic              grant_if;
    logic              grant_mem;
    logic              fin_if;
    logic              fin_mem;
    logic              if_deliver;

    assign if_ready  = !slot_if_vld;
    assign mem_ready = !slot_mem_vld;

    // Next-state and grant decision: MEM first unless a pending IF has waited out the starvation limit.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        fin_if    = 1'b0;
        fin_mem   = 1'b0;
        if_live   = slot_if_vld && !if_flush;
        case (state)
            IDLE: begin
                if (slot_mem_vld && !(if_live && starve_cnt >= CNT_LIMIT)) begin
                    grant_mem = 1'b1;
                    state_nxt = BUSY_MEM;
                end else if (if_live) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (mc_done) begin
                    fin_if    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_MEM: begin
                if (mc_done) begin
                    fin_mem   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A squashed or just-flushed fetch finishes silently.
        if_deliver = fin_if && !squash && !if_flush;
    end

    // State register, controller issue register, squash flag and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mc_req     <= 1'b0;
            mc_we      <= 1'b0;
            mc_size    <= 2'd0;
            mc_addr    <= '0;
            mc_wdata   <= '0;
            squash     <= 1'b0;
            starve_cnt <= '0;
        end else if (rdy) begin
            state  <= state_nxt;
            mc_req <= grant_if || grant_mem;
            if (grant_mem) begin
                mc_we    <= slot_mem_we;
                mc_size  <= slot_mem_size;
                mc_addr  <= slot_mem_addr;
                mc_wdata <= slot_mem_wdata;
            end else if (grant_if) begin
                mc_we    <= 1'b0;
                mc_size  <= 2'd2;
                mc_addr  <= slot_if_addr;
                mc_wdata <= '0;
            end
            squash <= (state == BUSY_IF) && !fin_if && (squash || if_flush);
            if (!if_live || grant_if) begin
                starve_cnt <= '0;
            end else if (grant_mem && starve_cnt < CNT_LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Request holding slots: accept when empty, clear on delivered completion; flush empties IF.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_if_vld    <= 1'b0;
            slot_if_addr   <= '0;
            slot_mem_vld   <= 1'b0;
            slot_mem_we    <= 1'b0;
            slot_mem_size  <= 2'd0;
            slot_mem_addr  <= '0;
            slot_mem_wdata <= '0;
        end else if (rdy) begin
            if (if_flush || if_deliver) begin
                slot_if_vld <= 1'b0;
            end else if (if_valid && !slot_if_vld) begin
                slot_if_vld  <= 1'b1;
                slot_if_addr <= if_addr;
            end
            if (fin_mem) begin
                slot_mem_vld <= 1'b0;
            end else if (mem_valid && !slot_mem_vld) begin
                slot_mem_vld   <= 1'b1;
                slot_mem_we    <= mem_we;
                slot_mem_size  <= (mem_size == 2'd3) ? 2'd2 : mem_size;
                slot_mem_addr  <= mem_addr;
                slot_mem_wdata <= mem_wdata;
            end
        end
    end

    // Completion pulses and returned data; read data holds between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_done   <= 1'b0;
            if_rdata  <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
        end else if (rdy) begin
            if_done  <= if_deliver;
            mem_done <= fin_mem;
            if (if_deliver) begin
                if_rdata <= mc_rdata;
            end
            if (fin_mem) begin
                mem_rdata <= slot_mem_we ? '0 : mc_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-level reference model of the arbitration rules.
// Directed scenarios first (fetch, MEM-first, store, flush, reset mid-transaction), then random traffic.
// A behavioural controller answers every issued request after a short delay and injects stray done pulses.
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          if_valid, if_ready, if_flush, if_done;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          mem_valid, mem_we, mem_ready, mem_done;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mc_req, mc_we, mc_done;
    logic [1:0]    mc_size;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_wdata, mc_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mc_req(mc_req), .mc_we(mc_we), .mc_size(mc_size), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        v;
        bit        we;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } req_t;

    req_t      q_if, q_mem;
    int        owner;      // who holds the controller: 0 nobody, 1 fetch, 2 load/store
    bit        squashed;   // fetch in flight has been flushed
    int        streak;     // MEM grants taken while a fetch waited
    bit        e_req, e_we, e_if_done, e_mem_done;
    bit [1:0]  e_size;
    bit [31:0] e_addr, e_wdata, e_if_rdata, e_mem_rdata;

    task automatic model_reset();
        q_if = '{default: 0};
        q_mem = '{default: 0};
        owner = 0; squashed = 0; streak = 0;
        e_req = 0; e_we = 0; e_size = 0; e_addr = 0; e_wdata = 0;
        e_if_done = 0; e_if_rdata = 0; e_mem_done = 0; e_mem_rdata = 0;
    endtask

    task automatic model_step();
        bit   fetch_waiting, pick_mem, pick_if, finish;
        req_t old_if, old_mem;
        if (rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        old_if  = q_if;
        old_mem = q_mem;
        fetch_waiting = old_if.v && !if_flush;
        pick_mem = (owner == 0) && old_mem.v && !(fetch_waiting && streak >= LIM);
        pick_if  = (owner == 0) && !pick_mem && fetch_waiting;
        finish   = (owner != 0) && mc_done;

        e_req = pick_mem || pick_if;
        e_if_done = 0;
        e_mem_done = 0;
        if (pick_mem) begin
            e_we = old_mem.we; e_size = old_mem.size; e_addr = old_mem.addr; e_wdata = old_mem.wdata;
        end
        if (pick_if) begin
            e_we = 0; e_size = 2; e_addr = old_if.addr; e_wdata = 0;
        end
        if (finish && owner == 2) begin
            e_mem_done = 1;
            e_mem_rdata = old_mem.we ? 32'h0 : mc_rdata;
            q_mem.v = 0;
        end
        if (finish && owner == 1 && !squashed && !if_flush) begin
            e_if_done = 1;
            e_if_rdata = mc_rdata;
            q_if.v = 0;
        end
        squashed = (owner == 1 && !finish) ? (squashed || if_flush) : 0;

        if (!fetch_waiting || pick_if) streak = 0;
        else if (pick_mem) streak = (streak + 1 > LIM) ? LIM : streak + 1;

        if (pick_mem) owner = 2;
        else if (pick_if) owner = 1;
        else if (finish) owner = 0;

        if (if_flush) q_if.v = 0;
        else if (!old_if.v && if_valid) begin
            q_if.v = 1; q_if.addr = if_addr;
        end
        if (!old_mem.v && mem_valid) begin
            q_mem.v = 1; q_mem.we = mem_we; q_mem.size = (mem_size == 3) ? 2'd2 : mem_size;
            q_mem.addr = mem_addr; q_mem.wdata = mem_wdata;
        end
    endtask

    // ---------------- behavioural controller ----------------
    bit        c_pend;
    int        c_wait;
    int        fixed_wait = -1;
    bit        stray_en = 0;
    bit        force_on = 0;
    logic [31:0] force_rdata;

    // Window statistics for directed scenarios.
    int        w_req, w_ifd, w_memd;
    logic [31:0] w_addr[$];
    logic        w_we;
    logic [1:0]  w_size;
    logic [31:0] w_wdata, w_ifdata, w_memdata;

    task automatic step_begin();
        @(negedge clk);
        check("if_ready",  if_ready,  !q_if.v);
        check("mem_ready", mem_ready, !q_mem.v);
        check("mc_req",    mc_req,    e_req);
        check("mc_we",     mc_we,     e_we);
        check("mc_size",   mc_size,   e_size);
        check("mc_addr",   mc_addr,   e_addr);
        check("mc_wdata",  mc_wdata,  e_wdata);
        check("if_done",   if_done,   e_if_done);
        check("if_rdata",  if_rdata,  e_if_rdata);
        check("mem_done",  mem_done,  e_mem_done);
        check("mem_rdata", mem_rdata, e_mem_rdata);
        if (rdy && mc_req) begin
            w_req++; w_addr.push_back(mc_addr);
            w_we = mc_we; w_size = mc_size; w_wdata = mc_wdata;
        end
        if (rdy && if_done)  begin w_ifd++;  w_ifdata  = if_rdata;  end
        if (rdy && mem_done) begin w_memd++; w_memdata = mem_rdata; end
        rst = 0; rdy = 1; if_valid = 0; if_flush = 0; mem_valid = 0;
    endtask

    task automatic step_end();
        mc_done = 0;
        mc_rdata = $urandom;
        if (c_pend && c_wait == 0) begin
            mc_done = 1;
            if (force_on) mc_rdata = force_rdata;
        end else if (stray_en && !c_pend && owner == 0 && $urandom_range(0, 15) == 0) begin
            mc_done = 1;
        end
        model_step();
        if (rdy) begin
            if (c_pend) begin
                if (c_wait == 0) c_pend = 0;
                else c_wait--;
            end
            if (mc_req) begin
                c_pend = 1;
                c_wait = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step_begin();
            step_end();
        end
    endtask

    task automatic clear_window();
        w_req = 0; w_ifd = 0; w_memd = 0; w_addr.delete();
    endtask

    initial begin
        rst = 1; rdy = 1; if_valid = 0; if_addr = 0; if_flush = 0;
        mem_valid = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        mc_done = 0; mc_rdata = 0; c_pend = 0; c_wait = 0; force_rdata = 0;
        model_reset();
        clear_window();
        repeat (2) @(posedge clk);

        // Fetch only: accept at t0, issue at t0+2, done one cycle after mc_done.
        fixed_wait = 0; force_on = 1; force_rdata = 32'hDEADBEEF;
        step_begin(); if_valid = 1; if_addr = 32'h100; step_end();
        step_begin(); step_end();
        step_begin();
        check("plan_if_req",  mc_req, 1'b1);
        check("plan_if_addr", mc_addr, 32'h100);
        check("plan_if_size", mc_size, 2'd2);
        check("plan_if_we",   mc_we, 1'b0);
        step_end();
        step_begin(); check("plan_req_pulse", mc_req, 1'b0); step_end();
        step_begin();
        check("plan_if_done",  if_done, 1'b1);
        check("plan_if_rdata", if_rdata, 32'hDEADBEEF);
        check("plan_if_ready", if_ready, 1'b1);
        step_end();
        idle_cycles(2);

        // Both valid at once: MEM read served first, then the fetch.
        clear_window(); force_rdata = 32'h000000AB;
        step_begin();
        if_valid = 1; if_addr = 32'h200;
        mem_valid = 1; mem_we = 0; mem_size = 0; mem_addr = 32'h1000; mem_wdata = 0;
        step_end();
        idle_cycles(12);
        check("both_req_count", w_req, 2);
        check("both_first",     (w_addr.size() > 0) ? w_addr[0] : 32'hX, 32'h1000);
        check("both_second",    (w_addr.size() > 1) ? w_addr[1] : 32'hX, 32'h200);
        check("both_mem_rdata", w_memdata, 32'h000000AB);
        check("both_if_done",   w_ifd, 1);

        // Store: direction, size and data reach the controller; load data reads back 0.
        clear_window(); force_rdata = 32'h5555AAAA;
        step_begin();
        mem_valid = 1; mem_we = 1; mem_size = 1; mem_addr = 32'h1004; mem_wdata = 32'h1234;
        step_end();
        idle_cycles(6);
        check("store_we",    w_we, 1'b1);
        check("store_size",  w_size, 2'd1);
        check("store_wdata", w_wdata, 32'h1234);
        check("store_done",  w_memd, 1);
        check("store_rdata", w_memdata, 32'h0);

        // Flush one cycle after issue: no done for it; a later fetch completes normally.
        clear_window(); fixed_wait = 2; force_rdata = 32'hCAFE0300;
        step_begin(); if_valid = 1; if_addr = 32'h2F0; step_end();
        step_begin(); step_end();
        step_begin(); step_end();
        step_begin(); if_flush = 1; step_end();
        step_begin(); if_valid = 1; if_addr = 32'h300; step_end();
        idle_cycles(12);
        check("flush_reqs",     w_req, 2);
        check("flush_second",   (w_addr.size() > 1) ? w_addr[1] : 32'hX, 32'h300);
        check("flush_if_done",  w_ifd, 1);
        check("flush_if_rdata", w_ifdata, 32'hCAFE0300);

        // Reset while MEM is in flight; the controller's late done must be ignored.
        clear_window(); fixed_wait = 3;
        step_begin(); mem_valid = 1; mem_we = 0; mem_size = 2; mem_addr = 32'h2000; step_end();
        step_begin(); step_end();
        step_begin(); step_end();
        step_begin(); rst = 1; step_end();
        idle_cycles(8);
        check("rst_mem_done", w_memd, 0);
        check("rst_reqs",     w_req, 1);

        // Random traffic checked cycle by cycle against the model.
        fixed_wait = -1; force_on = 0; stray_en = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step_begin();
            rst       = ($urandom_range(0, 299) == 0);
            rdy       = ($urandom_range(0, 99) < 85);
            if_valid  = ($urandom_range(0, 99) < 45);
            if_addr   = $urandom & 32'h0000_FFFC;
            if_flush  = ($urandom_range(0, 11) == 0);
            mem_valid = ($urandom_range(0, 99) < 45);
            mem_we    = $urandom_range(0, 1);
            mem_size  = $urandom_range(0, 3);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            step_end();
        end
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
